softmax_collector: RTL and testbench

Consumer-side endpoint of the softmax output stream. Accepts the unthrottled qout/out_valid element stream, assembles N-element rows, and double-buffers them. Replays each row as packed PACK-element words to the attention×V stage over a valid/ready handshake, with row and batch boundary flags. Absorbs the mismatch between softmax's no-backpressure output and a stallable downstream.

---
 rtl/softmax_pkg.sv | 15 +
 rtl/softmax_row_buf.sv | 50 +++++
 rtl/softmax_collector.sv | 124 ++++++++++++
 tb/tb_softmax_collector.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax output collector.
package softmax_pkg;

  localparam int DEF_D_W  = 8;
  localparam int DEF_N    = 32;
  localparam int DEF_ROWS = 32;
  localparam int DEF_PACK = 4;
  localparam int WORDS    = DEF_N / DEF_PACK;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/softmax_row_buf.sv
// Two-bank row storage: element-wide write port, PACK-element read port,
// and one full flag per bank.
module softmax_row_buf #(
  parameter int D_W  = 8,
  parameter int N    = 32,
  parameter int PACK = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic                             wr_bank,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_idx,
  input  logic [D_W-1:0]                   wr_data,
  input  logic                             set_full,
  input  logic                             clr_full,
  input  logic                             clr_bank,
  input  logic                             rd_bank,
  input  logic [(((N/PACK) > 1) ? $clog2(N/PACK) : 1)-1:0] rd_word,
  output logic [D_W*PACK-1:0]              rd_data,
  output logic [1:0]                       full
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [D_W-1:0] mem [2][N];
  logic [IW-1:0]  base;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= wr_data;
  end

  // set and clear never target the same bank: set needs an empty bank, clear a full one
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (set_full) full[wr_bank]  <= 1'b1;
      if (clr_full) full[clr_bank] <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    base    = IW'(rd_word * PACK);
    for (int k = 0; k < PACK; k++) begin
      rd_data[k*D_W +: D_W] = mem[rd_bank][base + IW'(k)];
    end
  end

endmodule

// File: rtl/softmax_collector.sv
// Collects the unthrottled softmax element stream into double-buffered rows
// and replays them as packed words over a stallable valid/ready interface.
module softmax_collector import softmax_pkg::*; #(
  parameter int D_W  = DEF_D_W,
  parameter int N    = DEF_N,
  parameter int ROWS = DEF_ROWS,
  parameter int PACK = DEF_PACK
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [D_W-1:0]      in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [D_W*PACK-1:0] out_data,
  output logic                out_last,
  output logic                out_batch_last,
  output logic                batch_done,
  output logic                overflow
);

  localparam int NW = N / PACK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (N % PACK != 0) begin : g_pack_check
    $error("softmax_collector: N must be a multiple of PACK");
  end

  rd_state_e         state_q, state_d;
  logic              wr_ptr, rd_ptr;
  logic [IW-1:0]     wr_idx;
  logic [WW-1:0]     rd_word;
  logic [RW-1:0]     rd_row;
  logic [1:0]        full;
  logic [D_W*PACK-1:0] rd_data;
  logic              push, drop, row_done, xfer, word_last, row_sent;
  logic              rd_bank_ready, other_bank_ready;

  // A word moves only on a cycle with out_valid && out_ready; while out_valid
  // is high and out_ready low, out_data and the flags stay frozen.
  assign push      = in_valid && enable && !full[wr_ptr];
  assign drop      = in_valid && enable &&  full[wr_ptr];
  assign row_done  = push && (wr_idx == IW'(N - 1));
  assign xfer      = out_valid && out_ready;
  assign word_last = (rd_word == WW'(NW - 1));
  assign row_sent  = xfer && word_last;

  // Include a bank completing on this very edge so a finished row is visible one cycle later
  assign rd_bank_ready    = full[rd_ptr]  || (row_done && (wr_ptr == rd_ptr));
  assign other_bank_ready = full[!rd_ptr] || (row_done && (wr_ptr != rd_ptr));

  softmax_row_buf #(.D_W(D_W), .N(N), .PACK(PACK)) u_row_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_bank  (wr_ptr),
    .wr_idx   (wr_idx),
    .wr_data  (in_data),
    .set_full (row_done),
    .clr_full (row_sent),
    .clr_bank (rd_ptr),
    .rd_bank  (rd_ptr),
    .rd_word  (rd_word),
    .rd_data  (rd_data),
    .full     (full)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rd_bank_ready) state_d = SEND;
      SEND: if (row_sent && !other_bank_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid      = (state_q == SEND);
    out_last       = out_valid && word_last;
    out_batch_last = out_last && (rd_row == RW'(ROWS - 1));
    out_data       = out_valid ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      wr_idx     <= '0;
      rd_ptr     <= 1'b0;
      rd_word    <= '0;
      rd_row     <= '0;
      overflow   <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      batch_done <= xfer && out_batch_last;
      if (drop) overflow <= 1'b1;
      if (push) begin
        if (row_done) begin
          wr_idx <= '0;
          wr_ptr <= !wr_ptr;
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end
      if (xfer) begin
        if (word_last) begin
          rd_word <= '0;
          rd_ptr  <= !rd_ptr;
          rd_row  <= (rd_row == RW'(ROWS - 1)) ? '0 : rd_row + RW'(1);
        end else begin
          rd_word <= rd_word + WW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_softmax_collector.sv
// Directed and random checks of softmax_collector against a row/queue model.
module tb_softmax_collector;

  localparam int D_W  = 8;
  localparam int N    = 32;
  localparam int ROWS = 2;
  localparam int PACK = 4;
  localparam int NW   = N / PACK;
  localparam int W    = D_W * PACK;

  logic           clk = 1'b0;
  logic           rst, enable, in_valid, out_ready;
  logic [D_W-1:0] in_data;
  logic           out_valid, out_last, out_batch_last, batch_done, overflow;
  logic [W-1:0]   out_data;

  always #5 clk = ~clk;

  softmax_collector #(.D_W(D_W), .N(N), .ROWS(ROWS), .PACK(PACK)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_batch_last (out_batch_last),
    .batch_done     (batch_done),
    .overflow       (overflow)
  );

  int total = 0;
  int bad   = 0;

  // model: {batch_last, last, data} per expected word
  logic [W+1:0]   exp_q[$];
  logic [D_W-1:0] m_row[N];
  int             m_cnt, m_stored, m_rows;
  bit             m_ovf;
  int             xfers, bd_pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt    = 0;
    m_stored = 0;
    m_rows   = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic step();
    logic           p_rst, p_in, p_hs, p_stall, p_last, p_blast, exp_bd;
    logic [D_W-1:0] p_data;
    logic [W-1:0]   p_out;
    logic [W+1:0]   e;
    p_rst   = rst;
    p_in    = in_valid && enable;
    p_data  = in_data;
    p_hs    = out_valid && out_ready;
    p_stall = out_valid && !out_ready;
    p_out   = out_data;
    p_last  = out_last;
    p_blast = out_batch_last;
    @(posedge clk);
    #1;
    if (p_rst) begin
      model_reset();
      return;
    end
    exp_bd = 1'b0;
    if (p_in) begin
      if (m_stored < 2) begin
        m_row[m_cnt] = p_data;
        m_cnt++;
        if (m_cnt == N) begin
          for (int w = 0; w < NW; w++) begin
            logic [W-1:0] d;
            for (int k = 0; k < PACK; k++) d[k*D_W +: D_W] = m_row[w*PACK + k];
            exp_q.push_back({(w == NW-1) && (m_rows % ROWS == ROWS-1), w == NW-1, d});
          end
          m_rows++;
          m_cnt = 0;
          m_stored++;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (p_hs) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("spurious_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", p_out, e[W-1:0]);
        chk("word_last", p_last, e[W]);
        chk("word_batch_last", p_blast, e[W+1]);
        exp_bd = e[W+1];
        if (e[W]) m_stored--;
      end
    end
    if (p_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, p_out);
      chk("hold_last", out_last, p_last);
    end
    if (batch_done) bd_pulses++;
    chk("batch_done", batch_done, exp_bd);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic push_row(input int base);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      enable   = 1'b1;
      in_data  = D_W'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n, bubbles;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    xfers = 0; bd_pulses = 0;
    model_reset();
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_batch_last", out_batch_last, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    // single row, first word one cycle after the last element
    out_ready = 1'b1;
    push_row(0);
    chk("latency_valid", out_valid, 1);
    chk("first_word", out_data, 32'h03020100);
    drain(20);

    // backpressure with alternating ready
    out_ready = 1'b0;
    push_row(0);
    xfers = 0;
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 2 == 0);
      step();
    end
    chk("bp_xfers", xfers, 8);
    chk("bp_empty", exp_q.size(), 0);

    // two stored rows drain back to back
    out_ready = 1'b0;
    push_row(8'h10);
    push_row(8'h40);
    out_ready = 1'b1;
    xfers = 0;
    bubbles = 0;
    for (int i = 0; i < 16; i++) begin
      if (!out_valid) bubbles++;
      step();
    end
    chk("b2b_bubbles", bubbles, 0);
    chk("b2b_xfers", xfers, 16);

    // overflow: third row's first element is dropped
    out_ready = 1'b0;
    push_row(8'h60);
    push_row(8'h80);
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    in_valid = 1'b0;
    chk("overflow_set", overflow, 1);
    xfers = 0;
    drain(40);
    chk("ovf_xfers", xfers, 16);

    // reset in the middle of a send
    out_ready = 1'b1;
    push_row(8'hA0);
    xfers = 0;
    n = 0;
    while (xfers < 3 && n < 10) begin
      step();
      n++;
    end
    chk("mid_xfers", xfers, 3);
    do_reset();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_data", out_data, 0);
    push_row(0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_first", out_data, 32'h03020100);
    drain(20);

    // batch boundaries over two batches
    do_reset();
    bd_pulses = 0;
    out_ready = 1'b0;
    push_row(8'h20);
    push_row(8'h30);
    drain(40);
    out_ready = 1'b0;
    push_row(8'hC0);
    push_row(8'hE0);
    drain(40);
    step();
    chk("bd_pulses", bd_pulses, 2);

    // random traffic: slow consumer first, then a faster one
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 9) < 9);
      in_data   = D_W'($urandom);
      out_ready = (c < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      step();
    end
    in_valid = 1'b0;
    drain(200);
    chk("rand_overflow", overflow, m_ovf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
